// File: rtl/svetofor_pkg.sv
// Shared types and elaboration helpers for the traffic-light time base.
package svetofor_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Board clock cycles per half tick period; integer division truncates.
  function automatic int calc_half(input int clk_hz, input int tick_hz);
    return clk_hz / (tick_hz * 2);
  endfunction

  function automatic int calc_cnt_w(input int clk_hz, input int tick_hz);
    int half;
    half = calc_half(clk_hz, tick_hz);
    return (half < 2) ? 1 : $clog2(half);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge
// detect on the synchronised signal.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  // High for exactly one cycle per low-to-high transition of the input.
  assign o_edge = r_sync & ~r_prev;

endmodule

// File: rtl/svetofor_tick_gen.sv
// Half-second tick divider plus reset sequencer for the traffic-light
// controller, with pause (enable) and resynchronise (resync) controls.
module svetofor_tick_gen
  import svetofor_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 2,
  parameter int HOLD_TICKS = 4
) (
  input  logic time_signal,
  input  logic reset,
  input  logic enable,
  input  logic resync,
  output logic tick_out,
  output logic tick_pulse,
  output logic svet_reset
);

  localparam int HALF   = calc_half(CLK_HZ, TICK_HZ);
  localparam int CNT_W  = calc_cnt_w(CLK_HZ, TICK_HZ);
  localparam int HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(HALF - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  if (HALF < 2) begin : g_half_check
    $error("svetofor_tick_gen: CLK_HZ/(TICK_HZ*2) = %0d, must be at least 2", HALF);
  end

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_tick_out;
  logic                r_tick_pulse;
  logic                r_svet_reset;

  logic w_resync_edge;
  logic w_wrap;
  logic w_count_en;

  sync_edge u_sync_edge (
    .clk    (time_signal),
    .rst_n  (reset),
    .i_async(resync),
    .o_edge (w_resync_edge)
  );

  assign w_wrap     = (r_cnt == CNT_MAX);
  assign w_count_en = (r_state != ST_PAUSE);

  always_ff @(posedge time_signal or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_HOLD;
      r_cnt        <= '0;
      r_hold_cnt   <= '0;
      r_tick_out   <= 1'b0;
      r_tick_pulse <= 1'b0;
      r_svet_reset <= 1'b0;
    end else begin
      r_tick_pulse <= 1'b0;
      if (w_resync_edge) begin
        // Resync beats everything, including a wrap landing on the same edge.
        r_state      <= ST_HOLD;
        r_cnt        <= '0;
        r_hold_cnt   <= '0;
        r_tick_out   <= 1'b0;
        r_svet_reset <= 1'b0;
      end else begin
        // RUN always advances on its last edge, so a wrap coinciding with
        // enable falling still completes before PAUSE freezes the divider.
        if (w_count_en) begin
          if (w_wrap) begin
            r_cnt        <= '0;
            r_tick_out   <= ~r_tick_out;
            r_tick_pulse <= ~r_tick_out;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        case (r_state)
          ST_HOLD: begin
            if (w_wrap && !r_tick_out && (r_hold_cnt != HOLD_MAX)) begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
            // Release only on a falling tick so the controller gets half a
            // tick period of reset recovery before its next rising edge.
            if (w_wrap && r_tick_out && (r_hold_cnt == HOLD_MAX)) begin
              r_svet_reset <= 1'b1;
              r_state      <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (!enable) begin
              r_state <= ST_PAUSE;
            end
          end
          ST_PAUSE: begin
            if (enable) begin
              r_state <= ST_RUN;
            end
          end
          default: begin
            r_state <= ST_HOLD;
          end
        endcase
      end
    end
  end

  assign tick_out   = r_tick_out;
  assign tick_pulse = r_tick_pulse;
  assign svet_reset = r_svet_reset;

endmodule

// File: tb/tb_svetofor_tick_gen.sv
// Scoreboard bench for svetofor_tick_gen at CLK_HZ=16, TICK_HZ=2 (HALF=4),
// HOLD_TICKS=2; expected {tick_out, tick_pulse, svet_reset} per clock edge.
module tb_svetofor_tick_gen;

  localparam int CLK_HZ     = 16;
  localparam int TICK_HZ    = 2;
  localparam int HOLD_TICKS = 2;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b1;
  logic resync = 1'b0;
  logic tick_out;
  logic tick_pulse;
  logic svet_reset;

  typedef struct {
    string      tag;
    logic [2:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  svetofor_tick_gen #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .time_signal(clk),
    .reset      (rst_n),
    .enable     (enable),
    .resync     (resync),
    .tick_out   (tick_out),
    .tick_pulse (tick_pulse),
    .svet_reset (svet_reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: {tick_out,tick_pulse,svet_reset} got %b, expected %b", tag, got, exp);
  endtask

  task automatic push(input string tag, input logic to, input logic tp, input logic sr);
    exp_t e;
    e.tag = tag;
    e.val = {to, tp, sr};
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb_q.pop_front();
    check(e.tag, {tick_out, tick_pulse, svet_reset}, e.val);
  endtask

  // One clock edge, sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Asserts reset between edges, checks it takes effect without a clock,
  // releases it so the next posedge is edge 1.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push({tag, "_rst"}, 1'b0, 1'b0, 1'b0);
    pop_check();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Nominal power-up: rise/pulse at 4,12,20..., fall at 8,16,...; release at 16.
  task automatic power_up_trace(input string tag, input int n_edges);
    for (int n = 1; n <= n_edges; n++) begin
      push($sformatf("%s_e%0d", tag, n), (n % 8) >= 4, (n % 8) == 4, n >= 16);
      step();
    end
  endtask

  initial begin
    // Power-up with enable high.
    do_reset("s1");
    power_up_trace("s1", 29);

    // Reset mid-RUN while tick_out is high, then the identical sequence.
    do_reset("s2");
    power_up_trace("s2", 24);

    // Pause five edges starting with the counter at 1: rise slips 20 -> 25.
    do_reset("s3");
    power_up_trace("s3", 16);
    for (int n = 17; n <= 33; n++) begin
      enable = !(n >= 18 && n <= 22);
      if (n < 25) push($sformatf("s3_e%0d", n), 1'b0, 1'b0, 1'b1);
      else push($sformatf("s3_e%0d", n), ((n - 25) % 8) < 4, ((n - 25) % 8) == 0, 1'b1);
      step();
    end
    enable = 1'b1;

    // Three-cycle resync first sampled at k=17: HOLD from 19, release at 35.
    do_reset("s4");
    power_up_trace("s4", 16);
    for (int n = 17; n <= 41; n++) begin
      resync = (n >= 17 && n <= 19);
      if (n < 19) push($sformatf("s4_e%0d", n), 1'b0, 1'b0, 1'b1);
      else push($sformatf("s4_e%0d", n), ((n - 19) % 8) >= 4, ((n - 19) % 8) == 4, n >= 35);
      step();
    end
    resync = 1'b0;

    // Resync event lands on edge 20, where a rise would otherwise occur.
    do_reset("s5");
    power_up_trace("s5", 16);
    for (int n = 17; n <= 40; n++) begin
      resync = (n == 18);
      if (n < 20) push($sformatf("s5_e%0d", n), 1'b0, 1'b0, 1'b1);
      else push($sformatf("s5_e%0d", n), ((n - 20) % 8) >= 4, ((n - 20) % 8) == 4, n >= 36);
      step();
    end
    resync = 1'b0;

    // Enable low from power-up: release still at 16, then frozen low.
    enable = 1'b0;
    do_reset("s6");
    power_up_trace("s6", 16);
    for (int n = 17; n <= 30; n++) begin
      push($sformatf("s6_e%0d", n), 1'b0, 1'b0, 1'b1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/svetofor_tick_gen.md
# svetofor_tick_gen

Time base and reset sequencer for the traffic-light controller. Divides the board clock into the half-second square wave that the light controller uses as its clock. Generates a clean active-low reset for that controller that is released only on a falling edge of the tick. Also provides pause and resynchronise controls for the whole light sequence.

## Interface
Parameters:
- CLK_HZ, 50_000_000, board clock frequency in Hz
- TICK_HZ, 2, tick frequency in Hz (one tick rising edge per half second)
- HOLD_TICKS, 4, number of tick pulses the downstream reset is held low after reset or resync

Ports:
- time_signal  in  1  board clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low; one clock, no other reset
- enable  in  1  run/pause; synchronous, level-sensitive
- resync  in  1  asynchronous request (button); synchronised internally, acts on its rising edge
- tick_out  out  1  50 % square wave at TICK_HZ; drives the controller's time_signal
- tick_pulse  out  1  one-cycle strobe coincident with each tick_out rise
- svet_reset  out  1  active-low reset for the light controller

## Operation
- HALF = CLK_HZ / (TICK_HZ*2) clock cycles per half-period.
  - Elaboration error if HALF < 2.
  - Counter width is $clog2(HALF).
  - Integer division truncates.
- Divider behaviour:
  - Counter increments each active cycle.
  - At HALF-1 it wraps to 0 and tick_out toggles.
  - A 0->1 toggle asserts tick_pulse for that cycle.
- State machine, states HOLD, RUN and PAUSE:
  - HOLD:
    - svet_reset=0 and the divider runs; enable is ignored.
    - Tick pulses are counted; the HOLD count saturates at HOLD_TICKS.
    - Once the count reaches HOLD_TICKS, the next tick_out 1->0 toggle sets svet_reset=1 and moves to RUN.
  - RUN:
    - The divider runs.
    - enable=0 moves to PAUSE at the next edge; the counter and tick_out hold from that edge onward.
  - PAUSE:
    - Counter and tick_out are frozen and no tick_pulse is produced.
    - enable=1 returns to RUN and counting resumes from the held value.
    - svet_reset stays 1.
- Resync:
  - resync passes a 2-flop synchroniser, then a rising-edge detect.
  - A detected edge in any state does the following at the next edge:
    - state=HOLD, counter=0, tick_out=0, HOLD count=0, svet_reset=0.
  - tick_pulse is suppressed that cycle.
- Priority: async reset > resync edge > HOLD release > enable.

## Timing
- Reset values:
  - tick_out=0, tick_pulse=0, svet_reset=0.
  - State HOLD; counter, HOLD count and synchroniser flops all 0.
  - Reset takes effect immediately, with no clock edge needed.
- All outputs are registered; there are no combinational paths from input to output.
- After reset release with enable=1:
  - First tick_out rise (and tick_pulse) on edge HALF.
  - Falls on edge 2*HALF; period 2*HALF.
- svet_reset rises exactly on a tick_out falling edge.
  - This gives the downstream reset recovery half a tick period before its next posedge.
- Resync latency: with resync first sampled high at edge k, svet_reset=0 and tick_out=0 from edge k+2.
  - A resync held high produces only one event; it must go low, then high again, to retrigger.
- Simultaneous events:
  - Resync edge on a wrap cycle: resync wins, with no pulse and no toggle.
  - enable falling on a wrap cycle while in RUN: the wrap and toggle complete on that edge, then PAUSE takes effect.
  - enable low throughout HOLD: release still occurs, then PAUSE on the following edge.
- A mid-operation async reset restores all reset values at once; the sequence restarts as after power-up.

## Structure
- Package svetofor_pkg holds:
  - The state enum (HOLD, RUN, PAUSE).
  - A function computing HALF and the counter width from CLK_HZ/TICK_HZ.
- One sub-module, sync_edge: 2-flop synchroniser plus registered rising-edge detect, with the same clock and reset as the top.
- The top contains the divider, the HOLD counter and the FSM.

## Test plan
All scenarios use CLK_HZ=16, TICK_HZ=2 (HALF=4) and HOLD_TICKS=2.
- Power-up, enable=1: tick_pulse at edges 4, 12 and 20; tick_out high during edges 4–7, low during 8–11; svet_reset rises at edge 16 and never at any other edge.
- Reset asserted mid-RUN between clock edges: tick_out=0, tick_pulse=0 and svet_reset=0 immediately; the sequence then repeats scenario 1 exactly.
- In RUN, enable=0 for 5 cycles starting at counter=1: counter and tick_out frozen and no pulses; the next tick_out rise comes exactly 5 cycles later than nominal.
- resync pulse, 3 cycles wide, in RUN at edge k: svet_reset=0 and tick_out=0 from k+2; pulses at k+6 and k+14; svet_reset=1 at k+18; only one HOLD entry.
- resync timed so its event lands on a wrap edge: no tick_pulse on that edge, state HOLD, counter 0.
- enable=0 held from power-up: svet_reset still rises at edge 16; tick_out is frozen low from edge 17 with no further pulses.
